// File: rtl/xbar_write_order_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : xbar_write_order_queue_if
// Description : Handshake bundle between the crossbar AW arbiter / W steering
//               logic and the per-slave write ordering queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface xbar_write_order_queue_if #(
  parameter int MASTERS   = 2,
  parameter int LEN_WIDTH = 4,
  parameter int DEPTH     = 8
);
  localparam int MW = $clog2(MASTERS);
  localparam int CW = $clog2(DEPTH) + 1;

  // AW grant side
  logic                 aw_push;
  logic [MW-1:0]        aw_src_master;
  logic [LEN_WIDTH-1:0] aw_len;
  logic                 aw_full;

  // W steering side
  logic                 w_route_valid;
  logic [MW-1:0]        w_src_master;
  logic                 w_expect_last;
  logic                 w_beat;
  logic                 w_last_in;

  // Status
  logic [CW-1:0]        outstanding;
  logic                 len_error;
  logic                 orphan_error;
  logic                 err_clear;

  // Crossbar side: issues grants and beats, observes routing/status
  modport master (
    output aw_push, aw_src_master, aw_len, w_beat, w_last_in, err_clear,
    input  aw_full, w_route_valid, w_src_master, w_expect_last,
           outstanding, len_error, orphan_error
  );

  // Queue side
  modport slave (
    input  aw_push, aw_src_master, aw_len, w_beat, w_last_in, err_clear,
    output aw_full, w_route_valid, w_src_master, w_expect_last,
           outstanding, len_error, orphan_error
  );
endinterface
`default_nettype wire

// File: rtl/xbar_write_order_queue.sv
`default_nettype none
// ============================================================================
// Module      : xbar_write_order_queue
// Description : In-order queue of granted AW transactions for one crossbar
//               slave port. Steers W beats to the head entry's master, counts
//               beats against its AWLEN and flags WLAST/length mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_write_order_queue #(
  parameter int MASTERS   = 2,
  parameter int LEN_WIDTH = 4,
  parameter int DEPTH     = 8
) (
  input  wire logic               ACLK,
  input  wire logic               ARESET,
  xbar_write_order_queue_if.slave bus
);
  localparam int MW = $clog2(MASTERS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = CW - 1;

  // Entry storage: data only, qualified by count so it needs no reset
  logic [MW-1:0]        src_mem_q [DEPTH];
  logic [LEN_WIDTH-1:0] len_mem_q [DEPTH];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 len_error_q, len_error_d;
  logic                 orphan_error_q, orphan_error_d;

  logic                 w_full;
  logic                 w_valid;
  logic                 w_push;
  logic                 w_beat_ok;
  logic                 w_at_last;
  logic                 w_pop;
  logic [MW-1:0]        w_head_src;
  logic [LEN_WIDTH-1:0] w_head_len;

  // Head decode and push/pop qualification from registered state only
  always_comb begin
    w_full     = (count_q == CW'(DEPTH));
    w_valid    = (count_q != '0);
    w_head_src = src_mem_q[rd_ptr_q];
    w_head_len = len_mem_q[rd_ptr_q];
    w_at_last  = (beat_cnt_q == w_head_len);
    w_push     = bus.aw_push & ~w_full;
    w_beat_ok  = bus.w_beat & w_valid;
    // The beat counter alone decides when a burst ends; WLAST is only checked
    w_pop      = w_beat_ok & w_at_last;
  end

  // Next-state for pointers, occupancy, beat counter and sticky errors
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    beat_cnt_d     = beat_cnt_q;
    len_error_d    = len_error_q;
    orphan_error_d = orphan_error_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (w_beat_ok) begin
      if (w_at_last) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    if (w_push && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (w_pop && !w_push) begin
      count_d = count_q - 1'b1;
    end

    // Clear first so a same-cycle set condition wins
    if (bus.err_clear) begin
      len_error_d    = 1'b0;
      orphan_error_d = 1'b0;
    end
    if (w_beat_ok && (bus.w_last_in != w_at_last)) begin
      len_error_d = 1'b1;
    end
    if (bus.w_beat && !w_valid) begin
      orphan_error_d = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      beat_cnt_q     <= '0;
      len_error_q    <= 1'b0;
      orphan_error_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      beat_cnt_q     <= beat_cnt_d;
      len_error_q    <= len_error_d;
      orphan_error_q <= orphan_error_d;
    end
  end

  // Entry write at the tail on an accepted grant
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      src_mem_q[wr_ptr_q] <= bus.aw_src_master;
      len_mem_q[wr_ptr_q] <= bus.aw_len;
    end
  end

  // Output mapping
  always_comb begin
    bus.aw_full       = w_full;
    bus.w_route_valid = w_valid;
    bus.w_src_master  = w_valid ? w_head_src : '0;
    bus.w_expect_last = w_valid & w_at_last;
    bus.outstanding   = count_q;
    bus.len_error     = len_error_q;
    bus.orphan_error  = orphan_error_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_xbar_write_order_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_write_order_queue
// Description : Directed scoreboard bench for xbar_write_order_queue. Each
//               accepted grant enqueues its expected beats {src, last}; a
//               negedge monitor pops one per routed beat and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_write_order_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  xbar_write_order_queue_if #(.MASTERS(2), .LEN_WIDTH(4), .DEPTH(8)) bus ();

  xbar_write_order_queue #(.MASTERS(2), .LEN_WIDTH(4), .DEPTH(8)) u_dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic src;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat the DUT routes must match the next expected beat
  always @(negedge clk) begin
    if (!rst && bus.w_beat && bus.w_route_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got routed beat src=%0d expected none at %0t",
                 bus.w_src_master, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_src", int'(bus.w_src_master), int'(mon_e.src));
        check("beat_last", int'(bus.w_expect_last), int'(mon_e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_aw(input int src, input int len, input bit accept);
    bus.aw_push       = 1'b1;
    bus.aw_src_master = 1'(src);
    bus.aw_len        = 4'(len);
    if (accept)
      for (int i = 0; i <= len; i++) exp_q.push_back(exp_t'{src: 1'(src), last: (i == len)});
    tick();
    bus.aw_push = 1'b0;
  endtask

  task automatic beat(input bit last);
    bus.w_beat    = 1'b1;
    bus.w_last_in = last;
    tick();
    bus.w_beat    = 1'b0;
    bus.w_last_in = 1'b0;
  endtask

  task automatic drain(input int len);
    for (int i = 0; i <= len; i++) beat(i == len);
  endtask

  task automatic beat_push(input bit last, input int src, input int len, input bit accept);
    bus.aw_push       = 1'b1;
    bus.aw_src_master = 1'(src);
    bus.aw_len        = 4'(len);
    if (accept)
      for (int i = 0; i <= len; i++) exp_q.push_back(exp_t'{src: 1'(src), last: (i == len)});
    bus.w_beat    = 1'b1;
    bus.w_last_in = last;
    tick();
    bus.aw_push   = 1'b0;
    bus.w_beat    = 1'b0;
    bus.w_last_in = 1'b0;
  endtask

  initial begin
    bus.aw_push       = 1'b0;
    bus.aw_src_master = '0;
    bus.aw_len        = '0;
    bus.w_beat        = 1'b0;
    bus.w_last_in     = 1'b0;
    bus.err_clear     = 1'b0;

    // Reset and idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_full", int'(bus.aw_full), 0);
    check("rst_valid", int'(bus.w_route_valid), 0);
    check("rst_outstanding", int'(bus.outstanding), 0);
    check("rst_len_err", int'(bus.len_error), 0);
    check("rst_orphan", int'(bus.orphan_error), 0);
    check("rst_src", int'(bus.w_src_master), 0);
    check("rst_expect_last", int'(bus.w_expect_last), 0);

    // Single-beat burst: visible one cycle after push
    push_aw(1, 0, 1);
    check("single_valid", int'(bus.w_route_valid), 1);
    check("single_src", int'(bus.w_src_master), 1);
    check("single_expect_last", int'(bus.w_expect_last), 1);
    check("single_outstanding", int'(bus.outstanding), 1);
    beat(1);
    check("single_done", int'(bus.outstanding), 0);

    // Ordering: src sequence 0,0,0,0,1,1,0
    push_aw(0, 3, 1);
    push_aw(1, 1, 1);
    push_aw(0, 0, 1);
    check("order_outstanding3", int'(bus.outstanding), 3);
    drain(3);
    check("order_outstanding2", int'(bus.outstanding), 2);
    drain(1);
    drain(0);
    check("order_outstanding0", int'(bus.outstanding), 0);
    check("order_len_err", int'(bus.len_error), 0);

    // Fill to DEPTH with wrap, reject 9th
    for (int i = 0; i < 8; i++) push_aw(i % 2, i % 3, 1);
    check("full_flag", int'(bus.aw_full), 1);
    check("full_outstanding", int'(bus.outstanding), 8);
    push_aw(1, 5, 0);
    check("full_reject", int'(bus.outstanding), 8);
    drain(0);
    drain(1);
    drain(2);
    check("after3_outstanding", int'(bus.outstanding), 5);
    check("after3_full", int'(bus.aw_full), 0);
    push_aw(1, 1, 1);
    push_aw(0, 2, 1);
    push_aw(1, 0, 1);
    check("refill_full", int'(bus.aw_full), 1);

    // Pop plus push while full: push rejected
    beat_push(1, 0, 3, 0);
    check("full_pushpop_outstanding", int'(bus.outstanding), 7);
    check("full_pushpop_full", int'(bus.aw_full), 0);
    drain(1); drain(2); drain(0); drain(1); drain(1);
    check("drain_to2", int'(bus.outstanding), 2);

    // Pop plus push at count=2: occupancy holds, new entry at tail
    beat(0);
    beat(0);
    beat_push(1, 0, 1, 1);
    check("pushpop_outstanding", int'(bus.outstanding), 2);
    drain(0);
    drain(1);
    check("pushpop_drained", int'(bus.outstanding), 0);
    check("pushpop_len_err", int'(bus.len_error), 0);

    // Early WLAST does not pop; missing WLAST still pops
    push_aw(0, 3, 1);
    push_aw(1, 1, 1);
    beat(0);
    beat(1);
    check("early_last_err", int'(bus.len_error), 1);
    check("early_last_nopop", int'(bus.outstanding), 2);
    beat(0);
    beat(1);
    check("early_last_pop", int'(bus.outstanding), 1);
    beat(0);
    beat(0);
    check("missing_last_pop", int'(bus.outstanding), 0);
    check("missing_last_err", int'(bus.len_error), 1);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    check("clear_len_err", int'(bus.len_error), 0);

    // Set beats clear in the same cycle
    bus.err_clear = 1'b1;
    bus.w_beat    = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    bus.w_beat    = 1'b0;
    check("orphan_priority", int'(bus.orphan_error), 1);
    check("orphan_no_state", int'(bus.outstanding), 0);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    check("orphan_cleared", int'(bus.orphan_error), 0);

    // Orphan then reset mid-burst
    beat(0);
    check("orphan_set", int'(bus.orphan_error), 1);
    push_aw(1, 7, 1);
    beat(0); beat(0); beat(0);
    check("midburst_outstanding", int'(bus.outstanding), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_outstanding", int'(bus.outstanding), 0);
    check("midrst_valid", int'(bus.w_route_valid), 0);
    check("midrst_orphan", int'(bus.orphan_error), 0);
    check("midrst_len_err", int'(bus.len_error), 0);
    push_aw(0, 3, 1);
    check("fresh_valid", int'(bus.w_route_valid), 1);
    check("fresh_expect_last", int'(bus.w_expect_last), 0);
    drain(3);
    check("fresh_done", int'(bus.outstanding), 0);
    check("fresh_len_err", int'(bus.len_error), 0);

    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
